// File: rtl/cp0_irq_pkg.sv
// rtl/cp0_irq_pkg.sv - CP0 register indices, bit positions and exception codes
package cp0_irq_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int CAUSE_BD  = 31;
  localparam int IM_BASE   = 10;
  localparam int EXC_LSB   = 2;
  localparam int EXC_W     = 5;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_irq_if.sv
// rtl/cp0_irq_if.sv - core-side bus between the pipeline and coprocessor 0
interface cp0_irq_if #(parameter int N_HWINT = 6);
  logic               en;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_in;
  logic [31:0]        vpc;
  logic               bd_in;
  logic [4:0]         exc_code_in;
  logic               exlclr;
  logic [N_HWINT-1:0] hwint;
  logic [31:0]        cp0_out;
  logic [31:0]        epc_out;
  logic               req;

  modport master (
    output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, exlclr, hwint,
    input  cp0_out, epc_out, req
  );

  modport slave (
    input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, exlclr, hwint,
    output cp0_out, epc_out, req
  );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and sticky match flag
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare <= wdata;
      end
      // Writing Compare acknowledges the timer even if a match lands this cycle.
      if (compare_we) begin
        pending <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_irq.sv
// rtl/cp0_irq.sv - coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception entry
module cp0_irq
  import cp0_irq_pkg::*;
#(
  parameter int          N_HWINT  = 6,
  parameter bit          TIMER_EN = 1'b1,
  parameter logic [31:0] PRID     = 32'h2024_0501
) (
  input  logic      clk,
  input  logic      reset,
  cp0_irq_if.slave  bus
);

  localparam logic [5:0] HW_MASK = 6'((7'd1 << N_HWINT) - 7'd1);
  localparam logic [5:0] IM_MASK = HW_MASK | (TIMER_EN ? 6'b10_0000 : 6'b00_0000);

  logic [5:0]  ip_q;
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [4:0]  exc_q;
  logic [31:0] epc_q;

  logic [5:0]  hw_ext;
  logic [5:0]  ip_vec;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_ok;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        tmr_pend;

  always_comb begin
    hw_ext = '0;
    hw_ext[N_HWINT-1:0] = bus.hwint;
  end

  // The timer shares IP7 with the top hardware line, as on MIPS32.
  assign ip_vec  = ip_q | {tmr_pend, 5'b0};
  assign int_req = ie_q & ~exl_q & (|(ip_vec & im_q));
  assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;
  assign wr_ok   = bus.en & ~req;

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_ok && bus.cp0_addr == REG_COUNT),
        .compare_we (wr_ok && bus.cp0_addr == REG_COMPARE),
        .wdata      (bus.cp0_in),
        .count      (count_val),
        .compare    (compare_val),
        .pending    (tmr_pend)
      );
    end else begin : g_no_timer
      assign count_val   = '0;
      assign compare_val = '0;
      assign tmr_pend    = 1'b0;
    end
  endgenerate

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_vec, 3'b0, exc_q, 2'b0};

  always_comb begin
    bus.cp0_out = '0;
    case (bus.cp0_addr)
      REG_SR:      bus.cp0_out = sr_val;
      REG_CAUSE:   bus.cp0_out = cause_val;
      REG_EPC:     bus.cp0_out = epc_q;
      REG_PRID:    bus.cp0_out = PRID;
      REG_COUNT:   bus.cp0_out = count_val;
      REG_COMPARE: bus.cp0_out = compare_val;
      default:     bus.cp0_out = '0;
    endcase
  end

  assign bus.epc_out = epc_q;
  assign bus.req     = req;

  always_ff @(posedge clk) begin
    if (reset) begin
      ip_q  <= '0;
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip_q <= hw_ext;
      if (req) begin
        exl_q <= 1'b1;
        exc_q <= int_req ? EXC_INT : bus.exc_code_in;
        bd_q  <= bus.bd_in;
        epc_q <= epc_target(bus.vpc, bus.bd_in);
      end else begin
        if (bus.exlclr) begin
          exl_q <= 1'b0;
        end
        if (bus.en) begin
          case (bus.cp0_addr)
            REG_SR: begin
              im_q  <= bus.cp0_in[IM_BASE +: 6] & IM_MASK;
              exl_q <= bus.cp0_in[SR_EXL];
              ie_q  <= bus.cp0_in[SR_IE];
            end
            REG_EPC: epc_q <= bus.cp0_in;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_irq.sv
// tb/tb_cp0_irq.sv - scoreboard bench for cp0_irq
module tb_cp0_irq;
  import cp0_irq_pkg::*;

  localparam logic [31:0] PRID_V = 32'h2024_0501;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  cp0_irq_if #(.N_HWINT(6)) bus ();

  cp0_irq #(.N_HWINT(6), .TIMER_EN(1'b1), .PRID(PRID_V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = 1'b0; bus.cp0_addr = '0; bus.cp0_in = '0; bus.vpc = '0;
    bus.bd_in = 1'b0; bus.exc_code_in = '0; bus.exlclr = 1'b0; bus.hwint = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.cp0_addr = a; bus.cp0_in = d;
    step();
    bus.en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_out;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(32'd0);
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_req got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0);
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_epc got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_sr got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_cause got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_count got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_COMPARE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_compare got=%h exp=%h", got, exp); end
  endtask

  task automatic test_exception();
    do_reset();
    bus.vpc = 32'h3010; bus.exc_code_in = EXC_OV;
    exp_q.push_back(32'd1); #1;
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL exc_req got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h3010);
    exp_q.push_back(32'h0000_0030);
    exp_q.push_back(32'h0000_0002);
    step();
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL exc_req_masked got=%h exp=%h", got, exp); end
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL exc_epc got=%h exp=%h", got, exp); end
    rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL exc_cause got=%h exp=%h", got, exp); end
    rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL exc_sr got=%h exp=%h", got, exp); end
    bus.exc_code_in = '0;
  endtask

  task automatic test_interrupt();
    do_reset();
    bus.vpc = 32'h4000;
    mtc0(REG_SR, 32'h0000_0401);
    exp_q.push_back(32'h0000_0401); rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_sr got=%h exp=%h", got, exp); end
    bus.hwint = 6'b000001;
    exp_q.push_back(32'd0); #1;
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_req_before_sample got=%h exp=%h", got, exp); end
    step();
    bus.exc_code_in = EXC_ADEL;
    exp_q.push_back(32'd1); #1;
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_req got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_0400); rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_ip got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_0403);
    exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h4000);
    step();
    bus.exc_code_in = '0;
    rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_sr_exl got=%h exp=%h", got, exp); end
    rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_exccode got=%h exp=%h", got, exp); end
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_epc got=%h exp=%h", got, exp); end
    bus.exlclr = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_0401);
    step();
    bus.exlclr = 1'b0;
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_eret_reenable got=%h exp=%h", got, exp); end
    rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL int_eret_sr got=%h exp=%h", got, exp); end
    bus.hwint = '0;
  endtask

  task automatic test_delay_slot();
    do_reset();
    bus.exc_code_in = EXC_RI; bus.bd_in = 1'b1; bus.vpc = 32'h3008;
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h8000_0028);
    exp_q.push_back(32'h3004);
    step();
    bus.exc_code_in = '0; bus.bd_in = 1'b0;
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bd_epc got=%h exp=%h", got, exp); end
    rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bd_cause got=%h exp=%h", got, exp); end
    rd(REG_EPC, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bd_epc_read got=%h exp=%h", got, exp); end
    do_reset();
    bus.exc_code_in = EXC_SYS; bus.bd_in = 1'b1; bus.vpc = 32'h0;
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    bus.exc_code_in = '0; bus.bd_in = 1'b0;
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bd_epc_wrap got=%h exp=%h", got, exp); end
  endtask

  task automatic test_timer();
    int n;
    do_reset();
    mtc0(REG_COMPARE, 32'd5);
    mtc0(REG_COUNT, 32'd0);
    mtc0(REG_SR, 32'h0000_8001);
    exp_q.push_back(32'd1); rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_count_start got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd1);
    n = 0;
    while (!bus.req && n < 20) begin
      step();
      n++;
    end
    got = 32'(n); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_latency got=%0d exp=%0d", got, exp); end
    got = 32'(bus.req); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_req got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_8000); rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_ip15 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd6); rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_count_at_req got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_8003);
    step();
    rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_sr_exl got=%h exp=%h", got, exp); end
    mtc0(REG_COMPARE, 32'd100);
    exp_q.push_back(32'h0000_0000); rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL tmr_clear got=%h exp=%h", got, exp); end
  endtask

  task automatic test_write_suppress();
    do_reset();
    bus.vpc = 32'h5000; bus.exc_code_in = EXC_SYS;
    bus.en = 1'b1; bus.cp0_addr = REG_EPC; bus.cp0_in = 32'h1234;
    exp_q.push_back(32'h5000);
    exp_q.push_back(32'h0000_0020);
    step();
    bus.en = 1'b0; bus.exc_code_in = '0;
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sup_epc got=%h exp=%h", got, exp); end
    rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sup_cause got=%h exp=%h", got, exp); end
    bus.en = 1'b1; bus.cp0_addr = REG_EPC; bus.cp0_in = 32'hABCD;
    exp_q.push_back(32'h5000); #1;
    got = bus.cp0_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_during_wr got=%h exp=%h", got, exp); end
    exp_q.push_back(32'hABCD);
    step();
    bus.en = 1'b0;
    got = bus.epc_out; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL epc_write got=%h exp=%h", got, exp); end
  endtask

  task automatic test_edges();
    do_reset();
    exp_q.push_back(32'd0); rd(5'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmapped got=%h exp=%h", got, exp); end
    exp_q.push_back(PRID_V); rd(REG_PRID, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL prid got=%h exp=%h", got, exp); end
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    exp_q.push_back(32'd0); rd(REG_CAUSE, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL cause_ro got=%h exp=%h", got, exp); end
    mtc0(REG_COUNT, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF); rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL count_load got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0);
    step();
    rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL count_wrap got=%h exp=%h", got, exp); end
    mtc0(REG_SR, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_FC03); rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sr_mask got=%h exp=%h", got, exp); end
    mtc0(REG_EPC, 32'hDEAD_0000);
    do_reset();
    exp_q.push_back(32'd0); rd(REG_SR, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_mid_sr got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_EPC, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_mid_epc got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(REG_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_mid_count got=%h exp=%h", got, exp); end
  endtask

  initial begin
    idle();
    test_reset();
    test_exception();
    test_interrupt();
    test_delay_slot();
    test_timer();
    test_write_suppress();
    test_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_irq.md
Name: cp0_irq

Overview:
- Parametrised coprocessor-0 for the MIPS core. It adds up to 6 level-sensitive hardware interrupt lines, an internal Count/Compare timer, delay-slot (BD) tracking and a configurable PRId.
- Sits beside the GRF/DM in the execute/memory boundary.
- Takes the prioritised exception code from the core and produces req and EPC for the PC unit. It also serves mfc0 reads and mtc0 writes.

Parameters:
- N_HWINT, 6, number of external interrupt lines (1..6), mapped to Cause.IP/SR.IM bits [10 +: N_HWINT].
- TIMER_EN, 1, enables the Count/Compare timer; its pending flag ORs into IP bit 15.
- PRID, 32'h2024_0501, constant value returned for register 15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state on the rising clk edge
- en  in  1  mtc0 write enable
- cp0_addr  in  5  register select for read and write
- cp0_in  in  32  mtc0 write data
- vpc  in  32  PC of the instruction being committed/excepted
- bd_in  in  1  current instruction is in a branch delay slot
- exc_code_in  in  5  prioritised exception code; 0 = none
- exlclr  in  1  eret commit, clears EXL
- hwint  in  N_HWINT  external interrupt levels
- cp0_out  out  32  combinational read data
- epc_out  out  32  EPC register value
- req  out  1  take exception/interrupt this cycle (combinational)

Behaviour:
- Architectural registers:
  - SR (12): IM[10 +: N_HWINT] plus IM[15] when TIMER_EN, EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[10 +: N_HWINT], IP[15] = timer pending, ExcCode[6:2]; read-only to mtc0.
  - EPC (14): full 32 bits, read/write.
  - PRId (15): constant PRID.
  - Count (9) and Compare (11): read/write only when TIMER_EN; otherwise they read 0 and ignore writes.
- Reset: SR, Cause, EPC, Count, Compare and timer pending are all 0; req = 0; cp0_out follows the mux.
- IP sampling:
  - Cause.IP[10 +: N_HWINT] <= hwint every cycle (1-cycle registered sample; no latching).
  - Deasserting hwint clears IP on the next edge.
- Interrupt and exception requests:
  - int_req = IE & !EXL & |(IP & IM), using registered IP.
  - exc_req = (exc_code_in != 0) & !EXL.
  - req = int_req | exc_req.
- On a req edge:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in (interrupt has priority).
  - BD <= bd_in.
  - EPC <= bd_in ? vpc - 4 : vpc (32-bit wrap; unaligned vpc is stored unmodified).
- mtc0 when en & !req:
  - Write to the selected register with the write mask above.
  - If req is high the same cycle, the write is suppressed.
- eret (exlclr):
  - EXL <= 0 at the edge.
  - If req is high the same cycle, the req update wins and EXL stays 1.
- cp0_out:
  - Combinational mux on cp0_addr; unmapped addresses return 0.
  - A read in the cycle of a write returns the old value.
- Timer (TIMER_EN = 1):
  - Count increments every cycle and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count loads cp0_in instead of incrementing.
  - Pending sets when Count == Compare and Compare != 0, and stays sticky.
  - Any mtc0 to Compare clears pending; clearing wins over a same-cycle set.
- epc_out = EPC register; a new EPC is visible the cycle after req.
- No other state; a reset mid-exception returns everything to reset values.

Decomposition:
- Shared package/constants header (alongside the existing constants file):
  - CP0 register indices: SR = 12, CAUSE = 13, EPC = 14, PRID = 15, COUNT = 9, COMPARE = 11.
  - Bit positions: EXL, IE, BD, IM/IP base 10, ExcCode field.
  - ExcCode values: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12.
- One natural sub-module: cp0_timer (Count/Compare/pending). It is instantiated under a generate guarded by TIMER_EN.

Test Plan:
- Exception: reset, then SR = 0, exc_code_in = 12, vpc = 32'h3010, bd_in = 0 -> req = 1; after the edge EPC = 32'h3010, ExcCode = 12, EXL = 1, req = 0 while EXL = 1.
- Interrupt: mtc0 SR = 32'h0000_0401, then hwint[0] = 1 -> IP[10] = 1 one cycle later, req = 1, ExcCode = 0; a simultaneous exc_code_in = 4 is ignored; exlclr then re-enables.
- Delay slot: exc_code_in = 10, bd_in = 1, vpc = 32'h3008 -> EPC = 32'h3004, BD = 1.
- Timer: mtc0 Compare = 5, Count = 0, SR = 32'h0000_8001 -> pending at Count = 5, then req; mtc0 Compare clears IP[15].
- Write suppression: en = 1 to EPC = 32'h1234 with exc_code_in = 8 in the same cycle -> EPC = vpc, not 32'h1234.
- Edge cases: Count = 32'hFFFF_FFFF wraps to 0; cp0_addr = 3 reads 0; PRId reads PRID; Cause write ignored; reset mid-EXL clears all state.
